// File: rtl/roll_button_conditioner.sv
// roll_button_conditioner: synchronizes and debounces a raw button into a roll level,
// a press pulse, a wrapping press count and a long-press flag.
module roll_button_conditioner #(
    parameter int DIV_W      = 10,
    parameter int DEB_TICKS  = 4,
    parameter int LONG_TICKS = 64
) (
    input  logic       wb_clk_i,
    input  logic       rst_n,
    input  logic       btn_in,
    output logic       roll,
    output logic       press_pulse,
    output logic       long_press,
    output logic [7:0] press_cnt,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    state_t             state;
    logic               meta;
    logic               sync;
    logic [DIV_W-1:0]   div;
    logic [3:0]         deb_cnt;
    logic [7:0]         hold_cnt;
    logic               tick;

    assign tick = &div;

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            div  <= '0;
        end else begin
            meta <= btn_in;
            sync <= meta;
            div  <= div + DIV_W'(1);
        end
    end

    // Level changes on sync take priority over a coincident tick in both wait states.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            roll        <= 1'b0;
            press_pulse <= 1'b0;
            long_press  <= 1'b0;
            press_cnt   <= '0;
            busy        <= 1'b0;
        end else begin
            press_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        if (deb_cnt == 4'(DEB_TICKS - 1)) begin
                            state       <= HELD;
                            roll        <= 1'b1;
                            press_pulse <= 1'b1;
                            press_cnt   <= press_cnt + 8'd1;
                            hold_cnt    <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + 4'd1;
                        end
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end else if (tick && hold_cnt != 8'(LONG_TICKS)) begin
                        hold_cnt   <= hold_cnt + 8'd1;
                        long_press <= (hold_cnt == 8'(LONG_TICKS - 1));
                    end
                end
                RELEASE_WAIT: begin
                    if (sync) begin
                        state <= HELD;
                    end else if (tick) begin
                        if (deb_cnt == 4'(DEB_TICKS - 1)) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            roll       <= 1'b0;
                            long_press <= 1'b0;
                            hold_cnt   <= '0;
                        end else begin
                            deb_cnt <= deb_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_roll_button_conditioner.sv
// tb_roll_button_conditioner: randomized button episodes with a transaction-level
// scoreboard of expected presses; a monitor pops one entry per press_pulse.
module tb_roll_button_conditioner;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic       roll;
    logic       press_pulse;
    logic       long_press;
    logic [7:0] press_cnt;
    logic       busy;

    typedef struct {
        int         start;
        logic [7:0] cnt;
        bit         lng;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         n_pulse = 0;
    int         n_exp = 0;
    int         cyc = 0;
    logic [7:0] exp_cnt = 8'd0;
    bit         in_press = 0;
    bit         seen_long = 0;
    bit         exp_long = 0;
    bit         prev_pulse = 0;

    roll_button_conditioner #(.DIV_W(2), .DEB_TICKS(3), .LONG_TICKS(5)) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .btn_in     (btn),
        .roll       (roll),
        .press_pulse(press_pulse),
        .long_press (long_press),
        .press_cnt  (press_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A clean press of h clocks; an optional low glitch of g clocks splits the hold.
    task automatic do_press(input int h, input bit lng, input int g, input int gap);
        exp_cnt = exp_cnt + 8'd1;
        q.push_back('{cyc, exp_cnt, lng});
        n_exp++;
        btn = 1'b1;
        wait_clk(3);
        chk("busy_on_entry", busy, 1);
        if (g > 0) begin
            wait_clk(h / 2 - 3);
            btn = 1'b0;
            wait_clk(g);
            btn = 1'b1;
            wait_clk(h - h / 2);
        end else begin
            wait_clk(h - 3);
        end
        chk("roll_held", roll, 1);
        chk("cnt_held", press_cnt, exp_cnt);
        chk("long_at_release", long_press, lng);
        btn = 1'b0;
        wait_clk(gap);
    endtask

    // Bounce runs of 1..5 clocks are far shorter than the accept window.
    task automatic do_bounce();
        int n;
        n = 2 * $urandom_range(2, 5);
        for (int i = 0; i < n; i++) begin
            btn = ~btn;
            wait_clk($urandom_range(1, 5));
        end
        btn = 1'b0;
        wait_clk(24);
        chk("bounce_busy", busy, 0);
        chk("bounce_roll", roll, 0);
        chk("bounce_cnt", press_cnt, exp_cnt);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            in_press   = 0;
            prev_pulse = 0;
        end else begin
            if (press_pulse) begin
                exp_t e;
                int   lat;
                n_pulse++;
                chk("pulse_width", prev_pulse, 0);
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got press_cnt %0d expected no pulse at cycle %0d", press_cnt, cyc);
                end else begin
                    e = q.pop_front();
                    lat = cyc - e.start;
                    chk("pulse_cnt", press_cnt, e.cnt);
                    chk("pulse_roll", roll, 1);
                    n_chk++;
                    if (lat < 11 || lat > 15) begin
                        n_fail++;
                        $display("FAIL accept_latency: got %0d expected 11..15", lat);
                    end
                    in_press  = 1;
                    seen_long = 0;
                    exp_long  = e.lng;
                end
            end
            if (long_press) seen_long = 1;
            if (in_press && !roll) begin
                chk("long_seen", seen_long, exp_long);
                chk("busy_after_release", busy, 0);
                chk("long_cleared", long_press, 0);
                in_press = 0;
            end
            prev_pulse = press_pulse;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        rst_n = 1'b0;
        btn   = 1'b0;
        #3;
        chk("rst_roll", roll, 0);
        chk("rst_pulse", press_pulse, 0);
        chk("rst_long", long_press, 0);
        chk("rst_cnt", press_cnt, 0);
        chk("rst_busy", busy, 0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);

        for (int i = 0; i < 256; i++) do_press(16, 0, 0, 24);
        chk("wrap_cnt", press_cnt, 0);
        chk("wrap_pulses", n_pulse, 256);

        for (int i = 0; i < 24; i++) begin
            kind = (i == 0) ? 1 : $urandom_range(0, 2);
            if (kind == 0) do_press($urandom_range(16, 24), 0, 0, $urandom_range(24, 40));
            else if (kind == 1) do_press($urandom_range(48, 60), 1, (i % 2 == 0) ? $urandom_range(1, 3) : 0, $urandom_range(24, 40));
            else do_bounce();
        end

        exp_cnt = exp_cnt + 8'd1;
        q.push_back('{cyc, exp_cnt, 0});
        n_exp++;
        btn = 1'b1;
        wait_clk(24);
        chk("pre_reset_roll", roll, 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_roll", roll, 0);
        chk("async_long", long_press, 0);
        chk("async_busy", busy, 0);
        chk("async_cnt", press_cnt, 0);
        chk("async_pulse", press_pulse, 0);
        wait_clk(3);
        rst_n = 1'b1;
        exp_cnt = 8'd1;
        q.push_back('{cyc, exp_cnt, 0});
        n_exp++;
        wait_clk(20);
        chk("post_reset_cnt", press_cnt, 1);
        btn = 1'b0;
        wait_clk(30);

        for (int i = 0; i < 100 && q.size() != 0; i++) wait_clk(1);
        chk("queue_empty", q.size(), 0);
        chk("total_pulses", n_pulse, n_exp);
        chk("final_cnt", press_cnt, exp_cnt);
        chk("final_busy", busy, 0);
        chk("final_roll", roll, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
